// File: rtl/scr1_dmem_arb.sv
// Two-port DMEM arbiter: shares one downstream data-memory port between the LSU (port 0)
// and a second requester (port 1), with one outstanding transaction at a time.
`default_nettype none

package scr1_dmem_arb_pkg;
  localparam int SCR1_DMEM_AWIDTH = 32;
  localparam int SCR1_DMEM_DWIDTH = 32;

  typedef enum logic {
    SCR1_MEM_CMD_RD = 1'b0,
    SCR1_MEM_CMD_WR = 1'b1
  } type_scr1_mem_cmd_e;

  typedef enum logic [1:0] {
    SCR1_MEM_WIDTH_BYTE  = 2'b00,
    SCR1_MEM_WIDTH_HWORD = 2'b01,
    SCR1_MEM_WIDTH_WORD  = 2'b10,
    SCR1_MEM_WIDTH_ERROR = 2'b11
  } type_scr1_mem_width_e;

  typedef enum logic [1:0] {
    SCR1_MEM_RESP_NOTRDY = 2'b00,
    SCR1_MEM_RESP_RDY_OK = 2'b01,
    SCR1_MEM_RESP_RDY_ER = 2'b10
  } type_scr1_mem_resp_e;
endpackage

module scr1_dmem_arb
  import scr1_dmem_arb_pkg::*;
#(
  parameter bit ARB_RR = 1'b1,
  parameter int AW     = SCR1_DMEM_AWIDTH,
  parameter int DW     = SCR1_DMEM_DWIDTH
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 p0_req,
  input  type_scr1_mem_cmd_e   p0_cmd,
  input  type_scr1_mem_width_e p0_width,
  input  logic [AW-1:0]        p0_addr,
  input  logic [DW-1:0]        p0_wdata,
  output logic                 p0_req_ack,
  output logic [DW-1:0]        p0_rdata,
  output type_scr1_mem_resp_e  p0_resp,
  input  logic                 p1_req,
  input  type_scr1_mem_cmd_e   p1_cmd,
  input  type_scr1_mem_width_e p1_width,
  input  logic [AW-1:0]        p1_addr,
  input  logic [DW-1:0]        p1_wdata,
  output logic                 p1_req_ack,
  output logic [DW-1:0]        p1_rdata,
  output type_scr1_mem_resp_e  p1_resp,
  output logic                 dmem_req,
  output type_scr1_mem_cmd_e   dmem_cmd,
  output type_scr1_mem_width_e dmem_width,
  output logic [AW-1:0]        dmem_addr,
  output logic [DW-1:0]        dmem_wdata,
  input  logic                 dmem_req_ack,
  input  logic [DW-1:0]        dmem_rdata,
  input  type_scr1_mem_resp_e  dmem_resp,
  output logic                 arb_busy,
  output logic                 arb_owner,
  output logic                 arb_err
);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_e;

  state_e state_q, state_d;
  logic   owner_q, owner_d;
  logic   last_q,  last_d;
  logic   err_q,   err_d;
  logic   sel;
  logic   resp_done;

  // With no request, sel falls to 0 so the downstream fields come from port 0.
  always_comb begin
    if (p0_req && p1_req) begin
      sel = ARB_RR ? ~last_q : 1'b0;
    end else begin
      sel = p1_req;
    end
  end

  assign dmem_cmd   = sel ? p1_cmd   : p0_cmd;
  assign dmem_width = sel ? p1_width : p0_width;
  assign dmem_addr  = sel ? p1_addr  : p0_addr;
  assign dmem_wdata = sel ? p1_wdata : p0_wdata;

  assign resp_done = (dmem_resp == SCR1_MEM_RESP_RDY_OK) ||
                     (dmem_resp == SCR1_MEM_RESP_RDY_ER);

  always_comb begin
    state_d    = state_q;
    owner_d    = owner_q;
    last_d     = last_q;
    err_d      = err_q;
    dmem_req   = 1'b0;
    p0_req_ack = 1'b0;
    p1_req_ack = 1'b0;
    p0_resp    = SCR1_MEM_RESP_NOTRDY;
    p1_resp    = SCR1_MEM_RESP_NOTRDY;
    p0_rdata   = '0;
    p1_rdata   = '0;
    case (state_q)
      ST_IDLE: begin
        dmem_req   = p0_req | p1_req;
        p0_req_ack = dmem_req & dmem_req_ack & ~sel;
        p1_req_ack = dmem_req & dmem_req_ack &  sel;
        if (dmem_req && dmem_req_ack) begin
          state_d = ST_BUSY;
          owner_d = sel;
          last_d  = sel;
        end
        // A completion with nothing outstanding is dropped and flagged.
        if (resp_done) begin
          err_d = 1'b1;
        end
      end
      ST_BUSY: begin
        if (owner_q) begin
          p1_resp  = dmem_resp;
          p1_rdata = dmem_rdata;
        end else begin
          p0_resp  = dmem_resp;
          p0_rdata = dmem_rdata;
        end
        if (resp_done) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      owner_q <= 1'b0;
      last_q  <= 1'b1;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      last_q  <= last_d;
      err_q   <= err_d;
    end
  end

  assign arb_busy  = (state_q == ST_BUSY);
  assign arb_owner = owner_q;
  assign arb_err   = err_q;

endmodule

`default_nettype wire

// File: tb/tb_scr1_dmem_arb.sv
// Directed bench for scr1_dmem_arb: one round-robin and one fixed-priority instance on shared stimulus.
`default_nettype none

module tb_scr1_dmem_arb;
  import scr1_dmem_arb_pkg::*;

  localparam logic [1:0]  N  = 2'b00;
  localparam logic [1:0]  OK = 2'b01;
  localparam logic [1:0]  ER = 2'b10;
  localparam logic [31:0] A0 = 32'h0000_0100;
  localparam logic [31:0] A1 = 32'h0000_0003;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic                 p0_req, p1_req, dmem_req_ack;
  type_scr1_mem_cmd_e   p0_cmd, p1_cmd;
  type_scr1_mem_width_e p0_width, p1_width;
  logic [31:0]          p0_addr, p1_addr, p0_wdata, p1_wdata, dmem_rdata;
  type_scr1_mem_resp_e  dmem_resp;

  logic                 rr_a0, rr_a1, rr_dreq, rr_busy, rr_owner, rr_err;
  logic [31:0]          rr_rd0, rr_rd1, rr_daddr, rr_dwdata;
  type_scr1_mem_resp_e  rr_r0, rr_r1;
  type_scr1_mem_cmd_e   rr_dcmd;
  type_scr1_mem_width_e rr_dwidth;

  logic                 fp_a0, fp_a1, fp_dreq, fp_busy, fp_owner, fp_err;
  logic [31:0]          fp_rd0, fp_rd1, fp_daddr, fp_dwdata;
  type_scr1_mem_resp_e  fp_r0, fp_r1;
  type_scr1_mem_cmd_e   fp_dcmd;
  type_scr1_mem_width_e fp_dwidth;

  scr1_dmem_arb #(.ARB_RR(1'b1), .AW(32), .DW(32)) u_rr (
    .clk(clk), .rst_n(rst_n),
    .p0_req(p0_req), .p0_cmd(p0_cmd), .p0_width(p0_width), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
    .p0_req_ack(rr_a0), .p0_rdata(rr_rd0), .p0_resp(rr_r0),
    .p1_req(p1_req), .p1_cmd(p1_cmd), .p1_width(p1_width), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
    .p1_req_ack(rr_a1), .p1_rdata(rr_rd1), .p1_resp(rr_r1),
    .dmem_req(rr_dreq), .dmem_cmd(rr_dcmd), .dmem_width(rr_dwidth), .dmem_addr(rr_daddr),
    .dmem_wdata(rr_dwdata), .dmem_req_ack(dmem_req_ack), .dmem_rdata(dmem_rdata), .dmem_resp(dmem_resp),
    .arb_busy(rr_busy), .arb_owner(rr_owner), .arb_err(rr_err)
  );

  scr1_dmem_arb #(.ARB_RR(1'b0), .AW(32), .DW(32)) u_fp (
    .clk(clk), .rst_n(rst_n),
    .p0_req(p0_req), .p0_cmd(p0_cmd), .p0_width(p0_width), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
    .p0_req_ack(fp_a0), .p0_rdata(fp_rd0), .p0_resp(fp_r0),
    .p1_req(p1_req), .p1_cmd(p1_cmd), .p1_width(p1_width), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
    .p1_req_ack(fp_a1), .p1_rdata(fp_rd1), .p1_resp(fp_r1),
    .dmem_req(fp_dreq), .dmem_cmd(fp_dcmd), .dmem_width(fp_dwidth), .dmem_addr(fp_daddr),
    .dmem_wdata(fp_dwdata), .dmem_req_ack(dmem_req_ack), .dmem_rdata(dmem_rdata), .dmem_resp(dmem_resp),
    .arb_busy(fp_busy), .arb_owner(fp_owner), .arb_err(fp_err)
  );

  typedef struct {
    logic        p0, p1, ack;
    logic [1:0]  resp;
    logic [31:0] rdata;
    logic        a0, a1, dreq;
    logic [31:0] daddr, dwdata;
    logic        dcmd;
    logic [1:0]  r0, r1;
    logic [31:0] rd0, rd1;
    logic        busy, owner, err;
  } vec_t;

  vec_t vecs[$];
  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic p0, p1, ack, input logic [1:0] resp, input logic [31:0] rdata,
                              input logic a0, a1, dreq, input logic [31:0] daddr, input logic dcmd,
                              input logic [1:0] r0, r1, input logic [31:0] rd0, rd1,
                              input logic busy, owner, err);
    vec_t v;
    v.p0 = p0; v.p1 = p1; v.ack = ack; v.resp = resp; v.rdata = rdata;
    v.a0 = a0; v.a1 = a1; v.dreq = dreq; v.daddr = daddr; v.dcmd = dcmd;
    v.dwdata = dcmd ? 32'hAB : 32'h0;
    v.r0 = r0; v.r1 = r1; v.rd0 = rd0; v.rd1 = rd1;
    v.busy = busy; v.owner = owner; v.err = err;
    return v;
  endfunction

  task automatic cmp(input string tag, input int idx, input vec_t v,
                     input logic a0, a1, input logic [1:0] r0, r1, input logic [31:0] rd0, rd1,
                     input logic dreq, input logic [31:0] daddr, dwdata, input logic dcmd,
                     input logic busy, owner, err);
    string p;
    p = $sformatf("%s v%0d", tag, idx);
    chk({p, " p0_req_ack"}, 32'(a0), 32'(v.a0));
    chk({p, " p1_req_ack"}, 32'(a1), 32'(v.a1));
    chk({p, " p0_resp"}, 32'(r0), 32'(v.r0));
    chk({p, " p1_resp"}, 32'(r1), 32'(v.r1));
    chk({p, " p0_rdata"}, rd0, v.rd0);
    chk({p, " p1_rdata"}, rd1, v.rd1);
    chk({p, " dmem_req"}, 32'(dreq), 32'(v.dreq));
    if (v.dreq) begin
      chk({p, " dmem_addr"}, daddr, v.daddr);
      chk({p, " dmem_wdata"}, dwdata, v.dwdata);
      chk({p, " dmem_cmd"}, 32'(dcmd), 32'(v.dcmd));
    end
    chk({p, " arb_busy"}, 32'(busy), 32'(v.busy));
    chk({p, " arb_owner"}, 32'(owner), 32'(v.owner));
    chk({p, " arb_err"}, 32'(err), 32'(v.err));
  endtask

  task automatic drive(input logic q0, q1, ack, input logic [1:0] resp, input logic [31:0] rdata);
    p0_req = q0; p1_req = q1; dmem_req_ack = ack;
    dmem_resp = type_scr1_mem_resp_e'(resp); dmem_rdata = rdata;
  endtask

  initial begin
    p0_cmd = SCR1_MEM_CMD_RD; p0_width = SCR1_MEM_WIDTH_WORD; p0_addr = A0; p0_wdata = 32'h0;
    p1_cmd = SCR1_MEM_CMD_WR; p1_width = SCR1_MEM_WIDTH_BYTE; p1_addr = A1; p1_wdata = 32'hAB;
    drive(0, 0, 0, N, 0);

    //          p0 p1 ak resp  rdata          a0 a1 dq daddr c  r0  r1  rd0           rd1    bsy own err
    vecs.push_back(mk(0, 0, 0, N,  32'h0,        0, 0, 0, 0,  0, N,  N,  32'h0,        32'h0, 0, 0, 0));
    vecs.push_back(mk(1, 0, 1, N,  32'h0,        1, 0, 1, A0, 0, N,  N,  32'h0,        32'h0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, N,  32'h0,        0, 0, 0, 0,  0, N,  N,  32'h0,        32'h0, 1, 0, 0));
    vecs.push_back(mk(0, 0, 0, OK, 32'hDEADBEEF, 0, 0, 0, 0,  0, OK, N,  32'hDEADBEEF, 32'h0, 1, 0, 0));
    vecs.push_back(mk(0, 0, 0, N,  32'h0,        0, 0, 0, 0,  0, N,  N,  32'h0,        32'h0, 0, 0, 0));
    vecs.push_back(mk(0, 1, 1, N,  32'h0,        0, 1, 1, A1, 1, N,  N,  32'h0,        32'h0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, ER, 32'h55,       0, 0, 0, 0,  0, N,  ER, 32'h0,        32'h55, 1, 1, 0));
    vecs.push_back(mk(0, 0, 0, N,  32'h0,        0, 0, 0, 0,  0, N,  N,  32'h0,        32'h0, 0, 1, 0));
    for (int i = 0; i < 3; i++)
      vecs.push_back(mk(1, 0, 0, N, 32'h0,       0, 0, 1, A0, 0, N,  N,  32'h0,        32'h0, 0, 1, 0));
    vecs.push_back(mk(1, 0, 1, N,  32'h0,        1, 0, 1, A0, 0, N,  N,  32'h0,        32'h0, 0, 1, 0));
    vecs.push_back(mk(0, 1, 1, N,  32'h0,        0, 0, 0, 0,  0, N,  N,  32'h0,        32'h0, 1, 0, 0));
    vecs.push_back(mk(0, 1, 1, OK, 32'h1234,     0, 0, 0, 0,  0, OK, N,  32'h1234,     32'h0, 1, 0, 0));
    vecs.push_back(mk(0, 1, 1, N,  32'h0,        0, 1, 1, A1, 1, N,  N,  32'h0,        32'h0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, N,  32'h0,        0, 0, 0, 0,  0, N,  N,  32'h0,        32'h0, 1, 1, 0));
    vecs.push_back(mk(0, 0, 0, OK, 32'h77,       0, 0, 0, 0,  0, N,  OK, 32'h0,        32'h77, 1, 1, 0));
    vecs.push_back(mk(0, 0, 0, N,  32'h0,        0, 0, 0, 0,  0, N,  N,  32'h0,        32'h0, 0, 1, 0));
    vecs.push_back(mk(0, 0, 0, OK, 32'h0,        0, 0, 0, 0,  0, N,  N,  32'h0,        32'h0, 0, 1, 0));
    vecs.push_back(mk(0, 0, 0, N,  32'h0,        0, 0, 0, 0,  0, N,  N,  32'h0,        32'h0, 0, 1, 1));
    vecs.push_back(mk(0, 0, 0, N,  32'h0,        0, 0, 0, 0,  0, N,  N,  32'h0,        32'h0, 0, 1, 1));

    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    foreach (vecs[i]) begin
      @(negedge clk);
      drive(vecs[i].p0, vecs[i].p1, vecs[i].ack, vecs[i].resp, vecs[i].rdata);
      #1;
      cmp("rr", i, vecs[i], rr_a0, rr_a1, rr_r0, rr_r1, rr_rd0, rr_rd1, rr_dreq, rr_daddr, rr_dwdata,
          rr_dcmd, rr_busy, rr_owner, rr_err);
      cmp("fp", i, vecs[i], fp_a0, fp_a1, fp_r0, fp_r1, fp_rd0, fp_rd1, fp_dreq, fp_daddr, fp_dwdata,
          fp_dcmd, fp_busy, fp_owner, fp_err);
    end

    // Both ports contend: round-robin alternates starting at port 0, fixed priority keeps port 0.
    for (int k = 0; k < 8; k++) begin
      int g;
      @(negedge clk);
      drive(1, 1, 1, (k % 2) ? OK : N, (k % 2) ? 32'(k) : 32'h0);
      #1;
      g = (k / 2) % 2;
      if (k % 2 == 0) begin
        chk($sformatf("conflict k%0d rr p0_req_ack", k), 32'(rr_a0), 32'(g == 0));
        chk($sformatf("conflict k%0d rr p1_req_ack", k), 32'(rr_a1), 32'(g == 1));
        chk($sformatf("conflict k%0d rr dmem_addr", k), rr_daddr, (g == 1) ? A1 : A0);
        chk($sformatf("conflict k%0d fp p0_req_ack", k), 32'(fp_a0), 32'd1);
        chk($sformatf("conflict k%0d fp p1_req_ack", k), 32'(fp_a1), 32'd0);
        chk($sformatf("conflict k%0d fp dmem_addr", k), fp_daddr, A0);
      end else begin
        chk($sformatf("conflict k%0d rr p0_resp", k), 32'(rr_r0), 32'((g == 0) ? OK : N));
        chk($sformatf("conflict k%0d rr p1_resp", k), 32'(rr_r1), 32'((g == 1) ? OK : N));
        chk($sformatf("conflict k%0d fp p0_resp", k), 32'(fp_r0), 32'(OK));
        chk($sformatf("conflict k%0d fp p1_resp", k), 32'(fp_r1), 32'(N));
        chk($sformatf("conflict k%0d fp p0_rdata", k), fp_rd0, 32'(k));
      end
    end

    @(negedge clk);
    drive(0, 1, 1, N, 0);
    #1;
    chk("fp p1 after p0 drop ack", 32'(fp_a1), 32'd1);
    chk("rr p1 after p0 drop ack", 32'(rr_a1), 32'd1);
    @(negedge clk);
    drive(0, 0, 0, OK, 32'hAA);
    #1;
    chk("fp p1 resp after drop", 32'(fp_r1), 32'(OK));
    chk("fp p1 rdata after drop", fp_rd1, 32'hAA);
    chk("fp p0 resp after drop", 32'(fp_r0), 32'(N));

    // Asynchronous reset mid-transaction, then a late completion.
    @(negedge clk);
    drive(1, 0, 1, N, 0);
    @(negedge clk);
    drive(0, 0, 0, N, 0);
    #1;
    chk("pre-reset rr arb_busy", 32'(rr_busy), 32'd1);
    chk("pre-reset rr arb_err", 32'(rr_err), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("reset rr arb_busy", 32'(rr_busy), 32'd0);
    chk("reset rr arb_err", 32'(rr_err), 32'd0);
    chk("reset fp arb_err", 32'(fp_err), 32'd0);
    chk("reset rr arb_owner", 32'(rr_owner), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    drive(0, 0, 0, OK, 32'h5A5A);
    #1;
    chk("late resp rr p0_resp", 32'(rr_r0), 32'(N));
    chk("late resp rr p0_rdata", rr_rd0, 32'h0);
    chk("late resp rr arb_err before edge", 32'(rr_err), 32'd0);
    @(negedge clk);
    drive(0, 0, 0, N, 0);
    #1;
    chk("late resp rr arb_err", 32'(rr_err), 32'd1);
    chk("late resp fp arb_err", 32'(fp_err), 32'd1);
    chk("late resp rr arb_busy", 32'(rr_busy), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/scr1_dmem_arb.md
# scr1_dmem_arb

Two-port data-memory arbiter that shares the single core DMEM interface between the LSU (port 0) and a second requester such as the debug system-bus accessor (port 1). It sits between the pipeline's LSU and the DMEM router. It forwards the winning request combinationally, tracks one outstanding transaction, and returns the response only to the port that owns it.

## Interface
- `ARB_RR`, 1: 1 = round-robin between ports; 0 = fixed priority, port 0 wins.
- `AW`, `SCR1_DMEM_AWIDTH`: address width.
- `DW`, `SCR1_DMEM_DWIDTH`: data width.
- `clk` in 1: core clock.
- `rst_n` in 1: reset, asynchronous, active-low.
- `p0_req`, `p1_req` in 1: request valid for port 0 / port 1. Held until acked.
- `p0_cmd`, `p1_cmd` in `type_scr1_mem_cmd_e`: RD/WR.
- `p0_width`, `p1_width` in `type_scr1_mem_width_e`: BYTE/HWORD/WORD.
- `p0_addr`, `p1_addr` in AW: address.
- `p0_wdata`, `p1_wdata` in DW: store data.
- `p0_req_ack`, `p1_req_ack` out 1: request accepted this cycle.
- `p0_rdata`, `p1_rdata` out DW: read data. Equals `dmem_rdata` for the owner, 0 otherwise.
- `p0_resp`, `p1_resp` out `type_scr1_mem_resp_e`: response for the owner, RESP_NOTRDY otherwise.
- `dmem_req`, `dmem_cmd`, `dmem_width`, `dmem_addr`, `dmem_wdata` out: downstream request.
- `dmem_req_ack` in 1, `dmem_rdata` in DW, `dmem_resp` in `type_scr1_mem_resp_e`: downstream handshake.
- `arb_busy` out 1: a transaction is outstanding.
- `arb_owner` out 1: port of the outstanding or last transaction.
- `arb_err` out 1: sticky flag for an unexpected response. Cleared only by reset.

## Operation
- States: IDLE and BUSY.
- Selection, in IDLE only:
  - One port requesting: that port is selected.
  - Both requesting, `ARB_RR`=1: the port that is not `last` is selected. `last` resets to 1, so port 0 wins the first conflict.
  - Both requesting, `ARB_RR`=0: port 0 is selected.
- IDLE:
  - `dmem_req` = `p0_req | p1_req`.
  - `dmem_cmd`, `dmem_width`, `dmem_addr`, `dmem_wdata` are muxed from the selected port.
  - With no request, these outputs are driven from port 0.
  - The selected port's `pX_req_ack` = `dmem_req_ack`. The other port's ack = 0.
- Accept (IDLE & `dmem_req` & `dmem_req_ack`): go to BUSY; `owner` ← selected port; `last` ← selected port.
- BUSY:
  - `dmem_req` = 0 and both acks = 0. No request is forwarded while a response is pending.
  - `dmem_resp` and `dmem_rdata` are routed to `owner`.
  - RDY_OK or RDY_ER: return to IDLE.
  - NOTRDY: stay in BUSY. There is no timeout.
- RDY_OK or RDY_ER arriving in IDLE: `arb_err` ← 1, the response is dropped (both `pX_resp` = NOTRDY), and the state does not change.
- `arb_busy` = (state == BUSY). `arb_owner` = `owner`.

## Timing
- Request path is zero-latency and purely combinational: `pX_req` → `dmem_req` and `dmem_req_ack` → `pX_req_ack`.
- Response path is zero-latency and combinational, gated by the registered `owner`.
- There is at least one bubble after a response: a new request is acked no earlier than the cycle after the response cycle.
- A request whose ack drops mid-wait may lose to the other port in a later cycle. Requesters must hold their request until acked.
- Reset values:
  - State IDLE, `owner` 0, `last` 1, `arb_err` 0.
  - `arb_busy` 0, `arb_owner` 0.
  - Acks are 0 and resps are NOTRDY with no inputs active.
- Reset asserted mid-transaction: immediately IDLE. A late response after reset release sets `arb_err` and is not delivered.
- A port deasserting its request in BUSY has no effect. Its response is still delivered when it arrives.

## Test plan
- Single LSU read:
  - Stimulus: `p0_req`=1, RD, WORD, addr 0x100; `dmem_req_ack`=1 in cycle 0; RDY_OK with `rdata` 0xDEADBEEF in cycle 2.
  - Response: `p0_req_ack`=1 in cycle 0; `arb_busy`=1 in cycles 1–2; `p0_resp`=RDY_OK and `p0_rdata`=0xDEADBEEF in cycle 2; `p1_resp`=NOTRDY throughout.
- Conflict, round-robin (`ARB_RR`=1):
  - Stimulus: both ports request continuously with ack always 1 and a response one cycle after each accept.
  - Response: grants go 0,1,0,1. `dmem_addr` follows the winner.
- Conflict, fixed priority (`ARB_RR`=0):
  - Stimulus: same as the round-robin case.
  - Response: port 0 wins every time. Port 1 is acked only once `p0_req` drops.
- Error routing:
  - Stimulus: port 1 writes SB to 0x3; `dmem_resp`=RDY_ER.
  - Response: `p1_resp`=RDY_ER, `p0_resp`=NOTRDY, and the state returns to IDLE.
- Backpressure:
  - Stimulus: `p0_req`=1 with `dmem_req_ack`=0 for 3 cycles.
  - Response: no state change and `p0_req_ack`=0 during the stall. The ack arrives in cycle 3.
- Unexpected response and reset:
  - Stimulus 1: RDY_OK in IDLE.
  - Response 1: `arb_err`=1, nothing is delivered, and `arb_err` stays set.
  - Stimulus 2: `rst_n` pulsed low during BUSY.
  - Response 2: state IDLE, `arb_err`=0, `arb_busy`=0.
